riscv_muldiv_unit: RTL and testbench
====================================

Name: riscv_muldiv_unit

Overview:
Parametrised RV32M/RV64M execute unit that sits beside the integer ALU in the EX stage. It decodes the opcode, funct3 and funct7 fields, accepts M-extension R-type operations through a valid/ready handshake, and computes the result. Multiply and divide run as iterative radix-2 sequences, with an optional single-cycle multiplier. The result is returned with a destination-register tag, and an output handshake supports backpressure.

Parameters:
XLEN, 32, operand/result width (32 or 64).
FAST_MUL, 0, 1 = MUL/MULH/MULHSU/MULHU use a combinational 2*XLEN product with latency 1; 0 = iterative.
CNT_W, $clog2(XLEN)+1, iteration counter width (derived; do not override).

Ports:
i_clk  in  1  clock, rising edge
i_rst_n  in  1  asynchronous active-low reset
i_valid  in  1  request valid
o_ready  out  1  unit can accept (state IDLE)
i_opcode  in  7  instruction opcode
i_funct3  in  3  instruction funct3
i_funct7  in  7  instruction funct7
i_rs1  in  XLEN  operand A (dividend / multiplicand)
i_rs2  in  XLEN  operand B (divisor / multiplier)
i_rd  in  5  destination tag
i_flush  in  1  synchronous pipeline flush
o_is_m  out  1  combinational: opcode==0110011 and funct7==0000001
o_valid  out  1  result valid
i_ready  in  1  consumer accepts result
o_result  out  XLEN  result
o_rd  out  5  tag captured at accept

Behaviour:
- Reset (async, i_rst_n=0): state IDLE; o_valid=0, o_result=0, o_rd=0, counter=0, all datapath registers 0. Release is synchronous to i_clk.
- Accept: on a rising edge with i_valid & o_ready & o_is_m. If o_is_m=0 the request is ignored and no state changes.
- funct3 decode: 000 MUL (low XLEN), 001 MULH (s*s high), 010 MULHSU (s*u high), 011 MULHU (u*u high), 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC for iterative ops.
  - IDLE -> DONE for special-case divides, and for multiplies when FAST_MUL=1.
  - CALC runs exactly XLEN iterations (counter counts down XLEN..1), then moves to FIX.
  - FIX applies sign correction and moves to DONE.
  - DONE holds o_valid=1 with a stable o_result/o_rd until i_ready=1; the next state is then IDLE.
- Latency from the accept edge to o_valid high: XLEN+2 cycles for iterative ops (34 for XLEN=32), 1 cycle for fast/special ops.
- o_ready=1 only in IDLE, so no accept is possible in the cycle a result is consumed.
- Signed operands: magnitudes are taken at accept. The sign is applied in FIX:
  - product is negated if the operand signs differ;
  - quotient is negated if the signs differ;
  - remainder takes the dividend's sign.
  - Division truncates toward zero.
- Special cases, resolved at accept with no iteration:
  - divisor==0: DIV/DIVU -> all ones; REM/REMU -> rs1.
  - DIV with rs1=-2^(XLEN-1), rs2=-1: quotient -2^(XLEN-1), REM -> 0.
- i_flush=1: state -> IDLE at the next edge from any state, o_valid drops, and the in-flight result is discarded. Flush has priority over an accept in the same cycle; a request presented with i_flush is not taken.
- o_result/o_rd keep their last value after the handshake until the next result is loaded.
- Reset mid-operation: immediate return to the reset values; no result is emitted.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (XLEN=32, FAST_MUL=0) -> o_result=0xFFFFFFEB, o_valid exactly 34 cycles after the accept edge; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
- MULH 0x80000000*0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF(-1)*0x00000002 -> 0xFFFFFFFF; repeat MUL with FAST_MUL=1 -> latency 1.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, both latency 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM of the same operands -> 0.
- Hold i_ready=0 for 10 cycles in DONE -> o_valid, o_result, o_rd stable and o_ready=0; raise i_ready -> IDLE next cycle with o_ready=1. Present i_valid with funct7=0000000 -> o_is_m=0 and the request is ignored.
- Assert i_flush at CALC iteration 5 -> IDLE next cycle with no o_valid; i_flush together with i_valid in IDLE -> no accept. Pulse i_rst_n low mid-CALC -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// RV32M/RV64M execute unit: radix-2 iterative multiply/divide with an optional
// single-cycle multiplier, valid/ready on both sides and a destination tag.
module riscv_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter int FAST_MUL = 0,
  parameter int CNT_W    = $clog2(XLEN) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_opcode,
  input  logic [2:0]      i_funct3,
  input  logic [6:0]      i_funct7,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [4:0]      i_rd,
  input  logic            i_flush,
  output logic            o_is_m,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic                r_neg_q;
  logic                r_neg_r;
  logic [CNT_W-1:0]    r_cnt;
  logic [2*XLEN-1:0]   r_a;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_b;
  logic [XLEN-1:0]     r_result;
  logic [4:0]          r_rd;

  logic                w_accept;
  logic                w_sgn_a;
  logic                w_sgn_b;
  logic                w_a_neg;
  logic                w_b_neg;
  logic [XLEN-1:0]     w_mag_a;
  logic [XLEN-1:0]     w_mag_b;
  logic                w_div_zero;
  logic                w_div_ovf;
  logic                w_special;
  logic [XLEN-1:0]     w_special_val;
  logic                w_fast;
  logic [2*XLEN-1:0]   w_fast_prod;
  logic [XLEN:0]       w_shift;
  logic [XLEN:0]       w_diff;
  logic [2*XLEN-1:0]   w_sum;

  // Product bits come from prod; quotient/remainder from quo/rem. Signs go on last.
  function automatic logic [XLEN-1:0] fix_result(
    input logic [2:0]        op,
    input logic              neg_q,
    input logic              neg_r,
    input logic [2*XLEN-1:0] prod,
    input logic [XLEN-1:0]   quo,
    input logic [XLEN-1:0]   rem
  );
    logic [2*XLEN-1:0] p;
    p = neg_q ? -prod : prod;
    if (!op[2])
      return (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    else if (op[1])
      return neg_r ? -rem : rem;
    else
      return neg_q ? -quo : quo;
  endfunction

  assign o_is_m   = (i_opcode == 7'b0110011) && (i_funct7 == 7'b0000001);
  assign o_ready  = (r_state == S_IDLE);
  assign o_valid  = (r_state == S_DONE);
  assign o_result = r_result;
  assign o_rd     = r_rd;
  assign w_accept = i_valid & o_ready & o_is_m & ~i_flush;

  // MUL is treated as signed*signed: its low half is identical either way.
  assign w_sgn_a = i_funct3[2] ? ~i_funct3[0] : (i_funct3[1:0] != 2'b11);
  assign w_sgn_b = i_funct3[2] ? ~i_funct3[0] : ~i_funct3[1];
  assign w_a_neg = w_sgn_a & i_rs1[XLEN-1];
  assign w_b_neg = w_sgn_b & i_rs2[XLEN-1];
  assign w_mag_a = w_a_neg ? -i_rs1 : i_rs1;
  assign w_mag_b = w_b_neg ? -i_rs2 : i_rs2;

  assign w_div_zero    = (i_rs2 == '0);
  assign w_div_ovf     = ~i_funct3[0] && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2 == '1);
  assign w_special     = i_funct3[2] & (w_div_zero | w_div_ovf);
  assign w_special_val = w_div_zero ? (i_funct3[1] ? i_rs1 : '1)
                                    : (i_funct3[1] ? '0 : i_rs1);
  assign w_fast        = (FAST_MUL != 0) && !i_funct3[2];
  assign w_fast_prod   = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};

  assign w_shift = {r_acc[XLEN-1:0], r_a[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_b};
  assign w_sum   = r_acc + r_a;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: if (w_accept) w_next = (w_special || w_fast) ? S_DONE : S_CALC;
        S_CALC: if (r_cnt == CNT_W'(1)) w_next = S_FIX;
        S_FIX:  w_next = S_DONE;
        S_DONE: if (i_ready) w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: r_a/r_b/r_acc are multiplicand/multiplier/product for multiplies and
  // quotient-dividend/divisor/remainder for divides.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_rd     <= '0;
    end else if (!i_flush) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= i_funct3;
            r_rd    <= i_rd;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= CNT_W'(XLEN);
            r_a     <= {{XLEN{1'b0}}, w_mag_a};
            r_b     <= w_mag_b;
            r_acc   <= '0;
            if (w_special)
              r_result <= w_special_val;
            else if (w_fast)
              r_result <= fix_result(i_funct3, w_a_neg ^ w_b_neg, w_a_neg, w_fast_prod,
                                     '0, '0);
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (!r_op[2]) begin
            if (r_b[0]) r_acc <= w_sum;
            r_a <= r_a << 1;
            r_b <= r_b >> 1;
          end else if (!w_diff[XLEN]) begin
            r_acc <= {{XLEN{1'b0}}, w_diff[XLEN-1:0]};
            r_a   <= {r_a[2*XLEN-1:XLEN], r_a[XLEN-2:0], 1'b1};
          end else begin
            r_acc <= {{XLEN{1'b0}}, w_shift[XLEN-1:0]};
            r_a   <= {r_a[2*XLEN-1:XLEN], r_a[XLEN-2:0], 1'b0};
          end
        end
        S_FIX: begin
          r_result <= fix_result(r_op, r_neg_q, r_neg_r, r_acc, r_a[XLEN-1:0],
                                 r_acc[XLEN-1:0]);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit: iterative DUT plus a FAST_MUL=1 DUT,
// expected results queued at issue time and compared when o_valid appears.
module tb_riscv_muldiv_unit;

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    int          lat;
  } expT;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        valid = 1'b0;
  logic        fValidIn = 1'b0;
  logic        flush = 1'b0;
  logic        ready = 1'b0;
  logic [6:0]  opcode = 7'b0110011;
  logic [6:0]  funct7 = 7'b0000001;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic [4:0]  rd = '0;

  logic        oReady, oIsM, oValid;
  logic [31:0] oResult;
  logic [4:0]  oRd;
  logic        fReady, fIsM, fValidOut;
  logic [31:0] fResult;
  logic [4:0]  fRd;

  int compared = 0;
  int mismatched = 0;
  expT expQ[$];

  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(0)) dut (
    .i_clk(clock), .i_rst_n(resetN), .i_valid(valid), .o_ready(oReady),
    .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7), .i_rs1(rs1), .i_rs2(rs2),
    .i_rd(rd), .i_flush(flush), .o_is_m(oIsM), .o_valid(oValid), .i_ready(ready),
    .o_result(oResult), .o_rd(oRd)
  );

  riscv_muldiv_unit #(.XLEN(32), .FAST_MUL(1)) dutFast (
    .i_clk(clock), .i_rst_n(resetN), .i_valid(fValidIn), .o_ready(fReady),
    .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7), .i_rs1(rs1), .i_rs2(rs2),
    .i_rd(rd), .i_flush(flush), .o_is_m(fIsM), .o_valid(fValidOut), .i_ready(ready),
    .o_result(fResult), .o_rd(fRd)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic bit isSpecial(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 0) || (!f3[0] && a == 32'h80000000 && b == 32'hFFFFFFFF));
  endfunction

  // Reference model built on the simulator's own 64-bit and signed arithmetic.
  function automatic logic [31:0] modelM(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int sa, sb;
    bit ovf;
    sa = a;
    sb = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    p = 0;
    case (f3)
      3'd0: p = longint'(sa) * longint'(sb);
      3'd1: p = longint'(sa) * longint'(sb);
      3'd2: p = longint'(sa) * longint'({32'b0, b});
      3'd3: p = longint'({32'b0, a}) * longint'({32'b0, b});
      3'd4: return (b == 0) ? 32'hFFFFFFFF : ovf ? a : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : a % b;
    endcase
    return (f3 == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  task automatic issueOp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] tag, input bit fast);
    expT e;
    @(negedge clock);
    opcode = 7'b0110011;
    funct7 = 7'b0000001;
    funct3 = f3;
    rs1 = a;
    rs2 = b;
    rd = tag;
    if (fast) fValidIn = 1'b1;
    else valid = 1'b1;
    e.result = modelM(f3, a, b);
    e.rd = tag;
    e.lat = ((fast && !f3[2]) || isSpecial(f3, a, b)) ? 1 : 34;
    expQ.push_back(e);
    @(posedge clock);
    #1;
    valid = 1'b0;
    fValidIn = 1'b0;
  endtask

  // Counts cycles from the accept edge until o_valid, bounded.
  task automatic waitResult(output logic [31:0] res, output logic [4:0] tag, output int lat,
                            output bit ok, input bit fast);
    ok = 1'b0;
    res = 'x;
    tag = 'x;
    lat = 1;
    for (int n = 0; n < 100; n++) begin
      if (fast ? fValidOut : oValid) begin
        res = fast ? fResult : oResult;
        tag = fast ? fRd : oRd;
        ok = 1'b1;
        return;
      end
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    ready = 1'b1;
    @(posedge clock);
    #1;
    ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    compared++;
    if (oValid !== 1'b0 || oResult !== 32'h0 || oRd !== 5'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_in: valid/result/rd got %b/%h/%0d, expected 0/0/0", oValid, oResult, oRd);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    @(posedge clock);
    #1;
    compared++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || fReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_out: ready/valid/fready got %b/%b/%b, expected 1/0/1", oReady, oValid, fReady);
    end
  endtask

  task automatic test_mul();
    logic [2:0]  f3s[4] = '{3'd0, 3'd3, 3'd1, 3'd2};
    logic [31:0] as[4]  = '{32'd7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs[4]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h00000002};
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    bit          ok;
    expT         e;
    for (int i = 0; i < 4; i++) begin
      issueOp(f3s[i], as[i], bs[i], 5'(i + 1), 1'b0);
      waitResult(res, tag, lat, ok, 1'b0);
      e = expQ.pop_front();
      compared++;
      if (!ok || res !== e.result || tag !== e.rd) begin
        mismatched++;
        $display("[TB] FAIL mul[%0d] result/rd: got %h/%0d, expected %h/%0d", i, res, tag, e.result, e.rd);
      end
      compared++;
      if (lat !== e.lat) begin
        mismatched++;
        $display("[TB] FAIL mul[%0d] latency: got %0d, expected %0d", i, lat, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_div();
    logic [2:0]  f3s[8] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] as[8]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                            32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] bs[8]  = '{32'd2, 32'd2, 32'd7, 32'd7,
                            32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    bit          ok;
    expT         e;
    for (int i = 0; i < 8; i++) begin
      issueOp(f3s[i], as[i], bs[i], 5'(i + 10), 1'b0);
      waitResult(res, tag, lat, ok, 1'b0);
      e = expQ.pop_front();
      compared++;
      if (!ok || res !== e.result || tag !== e.rd) begin
        mismatched++;
        $display("[TB] FAIL div[%0d] result/rd: got %h/%0d, expected %h/%0d", i, res, tag, e.result, e.rd);
      end
      compared++;
      if (lat !== e.lat) begin
        mismatched++;
        $display("[TB] FAIL div[%0d] latency: got %0d, expected %0d", i, lat, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    bit          ok;
    expT         e;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a = $urandom;
      b = (i % 3 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if (i % 4 == 1) a = -a;
      issueOp(f3, a, b, 5'($urandom_range(0, 31)), 1'b0);
      waitResult(res, tag, lat, ok, 1'b0);
      e = expQ.pop_front();
      compared++;
      if (!ok || res !== e.result || tag !== e.rd || lat !== e.lat) begin
        mismatched++;
        $display("[TB] FAIL rand[%0d] f3=%0d a=%h b=%h: got %h/%0d lat %0d, expected %h/%0d lat %0d",
                 i, f3, a, b, res, tag, lat, e.result, e.rd, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_fast_mul();
    logic [2:0]  f3s[3] = '{3'd0, 3'd1, 3'd2};
    logic [31:0] as[3]  = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs[3]  = '{32'hFFFFFFFD, 32'h80000000, 32'h00000002};
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    bit          ok;
    expT         e;
    for (int i = 0; i < 3; i++) begin
      issueOp(f3s[i], as[i], bs[i], 5'(i + 20), 1'b1);
      waitResult(res, tag, lat, ok, 1'b1);
      e = expQ.pop_front();
      compared++;
      if (!ok || res !== e.result || tag !== e.rd) begin
        mismatched++;
        $display("[TB] FAIL fast[%0d] result/rd: got %h/%0d, expected %h/%0d", i, res, tag, e.result, e.rd);
      end
      compared++;
      if (lat !== e.lat) begin
        mismatched++;
        $display("[TB] FAIL fast[%0d] latency: got %0d, expected %0d", i, lat, e.lat);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [4:0]  tag;
    int          lat;
    bit          ok;
    expT         e;
    issueOp(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd17, 1'b0);
    waitResult(res, tag, lat, ok, 1'b0);
    e = expQ.pop_front();
    compared++;
    if (!ok || res !== e.result || tag !== e.rd) begin
      mismatched++;
      $display("[TB] FAIL hold_first result/rd: got %h/%0d, expected %h/%0d", res, tag, e.result, e.rd);
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      compared++;
      if (oValid !== 1'b1 || oResult !== e.result || oRd !== e.rd || oReady !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL hold[%0d] valid/result/rd/ready: got %b/%h/%0d/%b, expected 1/%h/%0d/0",
                 i, oValid, oResult, oRd, oReady, e.result, e.rd);
      end
    end
    consume();
    compared++;
    if (oReady !== 1'b1 || oValid !== 1'b0 || oResult !== e.result || oRd !== e.rd) begin
      mismatched++;
      $display("[TB] FAIL release ready/valid/result/rd: got %b/%b/%h/%0d, expected 1/0/%h/%0d",
               oReady, oValid, oResult, oRd, e.result, e.rd);
    end
    @(negedge clock);
    funct7 = 7'b0000000;
    funct3 = 3'd0;
    valid = 1'b1;
    #1;
    compared++;
    if (oIsM !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL is_m_off: got %b, expected 0", oIsM);
    end
    @(posedge clock);
    #1;
    valid = 1'b0;
    compared++;
    if (oReady !== 1'b1 || oValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL non_m_ignored ready/valid: got %b/%b, expected 1/0", oReady, oValid);
    end
    funct7 = 7'b0000001;
    #1;
    compared++;
    if (oIsM !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL is_m_on: got %b, expected 1", oIsM);
    end
  endtask

  task automatic test_flush();
    expT e;
    bit  seen;
    issueOp(3'd5, 32'd1000, 32'd7, 5'd9, 1'b0);
    e = expQ.pop_front();
    repeat (4) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    compared++;
    if (oReady !== 1'b1 || oValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_calc ready/valid: got %b/%b, expected 1/0", oReady, oValid);
    end
    @(negedge clock);
    funct3 = 3'd0;
    rs1 = 32'd3;
    rs2 = 32'd3;
    valid = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    #1;
    valid = 1'b0;
    flush = 1'b0;
    compared++;
    if (oReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_accept ready: got %b, expected 1", oReady);
    end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (oValid) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_no_result: o_valid seen %b, expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    expT e;
    bit  seen;
    issueOp(3'd4, 32'hFFFFF000, 32'd13, 5'd27, 1'b0);
    e = expQ.pop_front();
    repeat (10) @(posedge clock);
    #2;
    resetN = 1'b0;
    #1;
    compared++;
    if (oValid !== 1'b0 || oResult !== 32'h0 || oRd !== 5'h0 || oReady !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_mid valid/result/rd/ready: got %b/%h/%0d/%b, expected 0/0/0/1",
               oValid, oResult, oRd, oReady);
    end
    @(posedge clock);
    @(negedge clock);
    resetN = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (oValid) seen = 1'b1;
    end
    compared++;
    if (seen !== 1'b0 || oResult !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_mid_after seen/result: got %b/%h, expected 0/0", seen, oResult);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_random();
    test_fast_mul();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
